// File: rtl/packet_byte_arbiter_if.sv
// Byte-stream bundle between NUM_SRC Avalon-ST byte sources, the arbiter and the packetizer sink.
// The arbiter connects through the slave modport; the source/sink side drives through master.
interface packet_byte_arbiter_if #(
  parameter int NUM_SRC = 4
);
  localparam int CW = $clog2(NUM_SRC);

  logic [NUM_SRC*8-1:0] asi_in_data;
  logic [NUM_SRC-1:0]   asi_in_valid;
  logic [NUM_SRC-1:0]   asi_in_ready;
  logic [7:0]           aso_out0_data;
  logic                 aso_out0_valid;
  logic                 aso_out0_ready;
  logic                 aso_out0_startofpacket;
  logic                 aso_out0_endofpacket;
  logic [CW-1:0]        aso_out0_channel;

  modport master (
    output asi_in_data, asi_in_valid, aso_out0_ready,
    input  asi_in_ready, aso_out0_data, aso_out0_valid,
    input  aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_channel
  );

  modport slave (
    input  asi_in_data, asi_in_valid, aso_out0_ready,
    output asi_in_ready, aso_out0_data, aso_out0_valid,
    output aso_out0_startofpacket, aso_out0_endofpacket, aso_out0_channel
  );
endinterface

// File: rtl/packet_byte_arbiter.sv
// Packet-granular round-robin byte arbiter; zero-latency passthrough, 1-cycle IDLE bubble per grant,
// downstream ready passed only to the granted source. ARB_PAD_EN adds zero-padding of stalled grants.
module packet_byte_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int PKT_BYTES = 256,
  parameter int TIMEOUT   = 16
) (
  input  logic                  clock_clk,
  input  logic                  reset_reset_n,
  packet_byte_arbiter_if.slave  bus,
  output logic                  arb_busy,
  output logic                  arb_pad_active
);
  localparam int CW = $clog2(NUM_SRC);
  localparam int BW = $clog2(PKT_BYTES + 1);

  typedef enum logic [1:0] {IDLE, STREAM, PAD} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] grant_q, grant_d;
  logic [CW-1:0] last_grant_q, last_grant_d;
  logic [BW-1:0] byte_cnt_q, byte_cnt_d;

  logic               found;
  logic [CW-1:0]      pick;
  int                 idx;
  logic [7:0]         src_dat;
  logic               src_vld;
  logic               last_byte;
  logic [7:0]         out_dat;
  logic               out_vld, out_sop, out_eop, pad_act;
  logic [CW-1:0]      out_chan;
  logic [NUM_SRC-1:0] in_rdy;

  // Rotating priority: the source after the previous owner is looked at first.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      idx = (int'(last_grant_q) + i) % NUM_SRC;
      if (!found && bus.asi_in_valid[idx]) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end
  end

  assign src_dat   = bus.asi_in_data[int'(grant_q)*8 +: 8];
  assign src_vld   = bus.asi_in_valid[grant_q];
  assign last_byte = (byte_cnt_q == BW'(PKT_BYTES - 1));

`ifdef ARB_PAD_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT > 0);
`endif

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    byte_cnt_d   = byte_cnt_q;
    out_dat      = 8'h00;
    out_vld      = 1'b0;
    out_sop      = 1'b0;
    out_eop      = 1'b0;
    out_chan     = '0;
    pad_act      = 1'b0;
    in_rdy       = '0;
`ifdef ARB_PAD_EN
    idle_cnt_d   = idle_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = STREAM;
        end
      end
      STREAM: begin
        out_dat         = src_dat;
        out_vld         = src_vld;
        out_sop         = src_vld && (byte_cnt_q == '0);
        out_eop         = src_vld && last_byte;
        out_chan        = grant_q;
        in_rdy[grant_q] = bus.aso_out0_ready;
        if (src_vld && bus.aso_out0_ready) begin
          if (last_byte) begin
            byte_cnt_d   = '0;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end
`ifdef ARB_PAD_EN
        if (src_vld) begin
          idle_cnt_d = '0;
        end else if (idle_cnt_q == IW'(TIMEOUT - 1)) begin
          idle_cnt_d = '0;
          state_d    = PAD;
        end else begin
          idle_cnt_d = idle_cnt_q + IW'(1);
        end
`endif
      end
`ifdef ARB_PAD_EN
      // Source has gone quiet: fill the rest of the packet with zeros to keep framing aligned.
      PAD: begin
        out_vld  = 1'b1;
        out_sop  = (byte_cnt_q == '0);
        out_eop  = last_byte;
        out_chan = grant_q;
        pad_act  = 1'b1;
        if (bus.aso_out0_ready) begin
          if (last_byte) begin
            byte_cnt_d   = '0;
            last_grant_d = grant_q;
            state_d      = IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + BW'(1);
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= CW'(NUM_SRC - 1);
      byte_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      byte_cnt_q   <= byte_cnt_d;
    end
  end

`ifdef ARB_PAD_EN
  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) idle_cnt_q <= '0;
    else                idle_cnt_q <= idle_cnt_d;
  end
`endif

  assign bus.aso_out0_data          = out_dat;
  assign bus.aso_out0_valid         = out_vld;
  assign bus.aso_out0_startofpacket = out_sop;
  assign bus.aso_out0_endofpacket   = out_eop;
  assign bus.aso_out0_channel       = out_chan;
  assign bus.asi_in_ready           = in_rdy;
  assign arb_busy                   = (state_q != IDLE);
  assign arb_pad_active             = pad_act;
endmodule

// File: tb/tb_packet_byte_arbiter.sv
// Directed bench for packet_byte_arbiter: reset, round-robin, single source, ready toggling,
// async reset mid-packet, and the stalled-source behaviour of the selected build.
module tb_packet_byte_arbiter;
  localparam int NS = 4;
  localparam int PB = 256;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arb_busy, arb_pad_active;

  always #5 clk = ~clk;

  packet_byte_arbiter_if #(.NUM_SRC(NS)) bus ();

  packet_byte_arbiter #(.NUM_SRC(NS), .PKT_BYTES(PB), .TIMEOUT(TO)) dut (
    .clock_clk      (clk),
    .reset_reset_n  (rst_n),
    .bus            (bus),
    .arb_busy       (arb_busy),
    .arb_pad_active (arb_pad_active)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int src_cnt[NS];
  int exp_cnt[NS];
  int cur_len, cyc_n, budget;
  int err_data, err_rdy, err_frame, err_idle;
  logic after_eop;
  logic [NS-1:0] took;
  int grant_log[$], len_log[$], sop_cyc[$], eop_cyc[$];
  logic [7:0] sop_dat[$], eop_dat[$];

  function automatic logic [7:0] src_byte(input int i, input int k);
    return 8'(k) ^ 8'(i << 5) ^ 8'((k >> 8) * 17);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    grant_log.delete(); len_log.delete(); sop_cyc.delete(); eop_cyc.delete();
    sop_dat.delete(); eop_dat.delete();
    err_data = 0; err_rdy = 0; err_frame = 0; err_idle = 0; cyc_n = 0;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NS; i++) begin
      src_cnt[i] = 0;
      exp_cnt[i] = 0;
    end
  endtask

  task automatic check_errs(input string pfx);
    check({pfx, "_data_errs"}, err_data, 0);
    check({pfx, "_rdy_errs"}, err_rdy, 0);
    check({pfx, "_frame_errs"}, err_frame, 0);
    check({pfx, "_idle_errs"}, err_idle, 0);
  endtask

  task automatic monitor();
    logic x;
    int ch;
    cyc_n++;
    ch = int'(bus.aso_out0_channel);
    x  = bus.aso_out0_valid && bus.aso_out0_ready;
    if (!arb_busy) begin
      if (bus.aso_out0_valid || bus.asi_in_ready != '0 || bus.aso_out0_startofpacket ||
          bus.aso_out0_endofpacket || bus.aso_out0_channel != '0 || arb_pad_active) err_idle++;
    end else begin
      if (after_eop) err_idle++;
      if (!bus.aso_out0_ready && bus.asi_in_ready != '0) err_rdy++;
      if (arb_pad_active && bus.asi_in_ready != '0) err_rdy++;
      if (bus.aso_out0_ready && !arb_pad_active && bus.asi_in_ready != (NS'(1) << ch)) err_rdy++;
      if (!arb_pad_active && bus.aso_out0_valid !== bus.asi_in_valid[ch]) err_data++;
      if (arb_pad_active && !bus.aso_out0_valid) err_data++;
      if (bus.aso_out0_startofpacket !== (bus.aso_out0_valid && cur_len == 0)) err_frame++;
      if (bus.aso_out0_endofpacket !== (bus.aso_out0_valid && cur_len == PB - 1)) err_frame++;
    end
`ifndef ARB_PAD_EN
    if (arb_pad_active) err_idle++;
`endif
    after_eop = x && bus.aso_out0_endofpacket;
    took = bus.asi_in_ready & bus.asi_in_valid;
    if (x) begin
      if (bus.aso_out0_startofpacket) begin
        grant_log.push_back(ch);
        sop_dat.push_back(bus.aso_out0_data);
        sop_cyc.push_back(cyc_n);
      end
      if (arb_pad_active) begin
        if (bus.aso_out0_data !== 8'h00) err_data++;
      end else begin
        if (bus.aso_out0_data !== src_byte(ch, exp_cnt[ch])) err_data++;
        exp_cnt[ch]++;
      end
      cur_len++;
      if (bus.aso_out0_endofpacket) begin
        len_log.push_back(cur_len);
        eop_dat.push_back(bus.aso_out0_data);
        eop_cyc.push_back(cyc_n);
        cur_len = 0;
      end
    end
  endtask

  task automatic settle();
    for (int i = 0; i < NS; i++) bus.asi_in_data[8*i +: 8] = src_byte(i, src_cnt[i]);
    #1;
  endtask

  // Called just after a falling edge; returns at the next falling edge.
  task automatic step();
    settle();
    monitor();
    @(posedge clk);
    for (int i = 0; i < NS; i++) if (took[i]) src_cnt[i]++;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [NS-1:0] v);
    rst_n = 1'b0;
    bus.asi_in_valid = v;
    repeat (2) step();
    rst_n = 1'b1;
    cur_len = 0;
    after_eop = 1'b0;
    clear_logs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall, pads;
    clear_counts();
    clear_logs();
    cur_len = 0;
    after_eop = 1'b0;
    bus.asi_in_valid   = '1;
    bus.aso_out0_ready = 1'b1;
    bus.asi_in_data    = '0;
    @(negedge clk);

    // Reset with every source requesting: all outputs quiet.
    settle();
    check("rst_valid", bus.aso_out0_valid, 0);
    check("rst_ready", bus.asi_in_ready, 0);
    check("rst_sop", bus.aso_out0_startofpacket, 0);
    check("rst_eop", bus.aso_out0_endofpacket, 0);
    check("rst_chan", bus.aso_out0_channel, 0);
    check("rst_data", bus.aso_out0_data, 0);
    check("rst_busy", arb_busy, 0);
    check("rst_pad", arb_pad_active, 0);
    step(); step();
    rst_n = 1'b1;
    settle();
    check("rel_idle_bubble", arb_busy, 0);
    step();
    settle();
    check("first_busy", arb_busy, 1);
    check("first_chan", bus.aso_out0_channel, 0);
    check("first_sop", bus.aso_out0_startofpacket, 1);
    check("first_ready", bus.asi_in_ready, 4'b0001);
    check("first_data", bus.aso_out0_data, 8'h00);

    // All sources valid: 0,1,2,3,0,1 then stop 37 bytes into the grant of source 2.
    budget = 0;
    while (!(grant_log.size() == 7 && cur_len == 37) && budget < 3000) begin
      step();
      budget++;
    end
    check("rr_budget_ok", budget < 3000, 1);
    check("rr_ngrants", grant_log.size(), 7);
    check("rr_g0", grant_log[0], 0);
    check("rr_g1", grant_log[1], 1);
    check("rr_g2", grant_log[2], 2);
    check("rr_g3", grant_log[3], 3);
    check("rr_g4", grant_log[4], 0);
    check("rr_g5", grant_log[5], 1);
    check("rr_g6", grant_log[6], 2);
    for (int k = 0; k < 6; k++) check("rr_len", len_log[k], 256);
    check("rr_bubble", sop_cyc[1] - eop_cyc[0], 2);
    check("rr_cnt0", exp_cnt[0], 512);
    check("rr_cnt1", exp_cnt[1], 512);
    check("rr_cnt2", exp_cnt[2], 293);
    check("rr_cnt3", exp_cnt[3], 256);
    check_errs("rr");

    // Asynchronous reset mid-grant: outputs drop before any clock edge.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", bus.aso_out0_valid, 0);
    check("arst_ready", bus.asi_in_ready, 0);
    check("arst_sop", bus.aso_out0_startofpacket, 0);
    check("arst_chan", bus.aso_out0_channel, 0);
    check("arst_busy", arb_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_len = 0;
    after_eop = 1'b0;
    clear_logs();
    step();
    settle();
    check("arst_restart_sop", bus.aso_out0_startofpacket, 1);
    check("arst_restart_chan", bus.aso_out0_channel, 0);
    check("arst_restart_data", bus.aso_out0_data, 8'h22);

    // Source 2 alone: two back-to-back grants to the same source.
    clear_counts();
    do_reset(4'b0100);
    budget = 0;
    while (len_log.size() < 2 && budget < 700) begin
      step();
      budget++;
    end
    check("single_npkts", len_log.size(), 2);
    check("single_g0", grant_log[0], 2);
    check("single_g1", grant_log[1], 2);
    check("single_len0", len_log[0], 256);
    check("single_len1", len_log[1], 256);
    check("single_sop0", sop_dat[0], 8'h40);
    check("single_sop1", sop_dat[1], 8'h51);
    check("single_eop0", eop_dat[0], 8'hBF);
    check("single_eop1", eop_dat[1], 8'hAE);
    check("single_bubble", sop_cyc[1] - eop_cyc[0], 2);
    check("single_span", eop_cyc[1] - sop_cyc[0], 512);
    check_errs("single");

    // Downstream ready toggling 1010... during a grant.
    clear_counts();
    do_reset('1);
    bus.aso_out0_ready = 1'b1;
    step();
    settle();
    check("tog_ready_hi", bus.asi_in_ready, 4'b0001);
    step();
    bus.aso_out0_ready = 1'b0;
    settle();
    check("tog_ready_lo", bus.asi_in_ready, 4'b0000);
    check("tog_valid_held", bus.aso_out0_valid, 1);
    step();
    budget = 0;
    while (len_log.size() < 1 && budget < 1200) begin
      bus.aso_out0_ready = (budget % 2 == 0);
      step();
      budget++;
    end
    bus.aso_out0_ready = 1'b1;
    check("tog_npkts", len_log.size(), 1);
    check("tog_g0", grant_log[0], 0);
    check("tog_len", len_log[0], 256);
    check("tog_span", eop_cyc[0] - sop_cyc[0], 510);
    check("tog_cnt0", exp_cnt[0], 256);
    check("tog_cnt1", exp_cnt[1], 0);
    check_errs("tog");

    // Source 1 stops after 100 bytes.
    clear_counts();
    do_reset(4'b0010);
    budget = 0;
    while (cur_len < 100 && budget < 400) begin
      step();
      budget++;
    end
    check("stop_at_100", cur_len, 100);
    bus.asi_in_valid = 4'b0000;
`ifdef ARB_PAD_EN
    stall = 0;
    while (!arb_pad_active && stall < 100) begin
      step();
      stall++;
    end
    check("pad_stall_cycles", stall, 16);
    pads = 0;
    while (arb_busy && pads < 400) begin
      if (arb_pad_active) pads++;
      step();
    end
    check("pad_bytes", pads, 156);
    check("pad_len", len_log[0], 256);
    check("pad_eop_data", eop_dat[0], 8'h00);
    check("pad_done_idle", arb_busy, 0);
    bus.asi_in_valid = 4'b0011;
    step();
    settle();
    check("pad_next_chan", bus.aso_out0_channel, 0);
    check("pad_next_sop", bus.aso_out0_startofpacket, 1);
`else
    stall = 0;
    pads = 0;
    repeat (40) begin
      step();
      stall++;
    end
    check("stall_busy", arb_busy, 1);
    check("stall_valid", bus.aso_out0_valid, 0);
    check("stall_pad", arb_pad_active, 0);
    check("stall_no_eop", len_log.size(), pads);
    bus.asi_in_valid = 4'b0010;
    budget = 0;
    while (len_log.size() < 1 && budget < 400) begin
      step();
      budget++;
    end
    check("stall_resume_len", len_log[0], 256);
    check("stall_resume_cnt", exp_cnt[1], 256);
`endif
    check_errs("stop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
